// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI bus arbiter.
//   state_t   - arbiter FSM states
//   REQ_INERT - requester index of the inertial sensor interface
//   REQ_A2D   - requester index of the battery A2D
//   umax      - unsigned maximum, used for parameter-derived widths
//   req_oh    - one-hot requester vector from a winner index
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam int unsigned REQ_INERT = 0;
    localparam int unsigned REQ_A2D   = 1;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [1:0] req_oh(input logic w);
        logic [1:0] oh;
        oh = 2'b00;
        if (w) oh[REQ_A2D] = 1'b1;
        else   oh[REQ_INERT] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/spi_arb_tmr.sv
// spi_arb_tmr: up-counter with synchronous clear and a programmable terminal count.
// Shared by the arbiter for the inter-transaction guard gap and the BUSY watchdog.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clr   - clear counter to zero (takes priority over en)
//   en    - count enable; the counter saturates at limit and never wraps
//   limit - terminal count value
//   tc    - high while the count equals limit
module spi_arb_tmr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI monarch between the inertial sensor interface (req 0)
// and the battery A2D (req 1). Round-robin, one transaction at a time, with a guard gap
// of GAP_CYCLES idle clocks after every transaction.
// Optional BUSY watchdog enabled by defining SPI_ARB_TMO_EN (TMO_CYCLES clocks).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req[1:0]            - level requests, held with cmd stable until own done
//   cmd0, cmd1          - SPI command words of requester 0 / 1
//   done[1:0], err[1:0] - one-clock completion / watchdog-abort pulses to the winner
//   rd_data             - last SPI read word, valid with done
//   gnt[1:0]            - one-hot grant, grant cycle through done cycle
//   spi_wrt, spi_cmd    - start strobe and latched command to the SPI monarch
//   spi_done, spi_rd_data - completion pulse and read data from the SPI monarch
//   ss_sel              - slave select route (0 inertial, 1 A2D)
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned TMO_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [15:0] rd_data,
    output logic [1:0]  gnt,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        ss_sel
);

    localparam int unsigned CW = $clog2(umax(umax(GAP_CYCLES, TMO_CYCLES), 1) + 1);
    // Terminal counts are N-1 because the counter sits at 0 on the first cycle of a state.
    localparam logic [CW-1:0] GAP_LIM = CW'(umax(GAP_CYCLES, 1) - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [15:0] spi_cmd_q, spi_cmd_d;
    logic        ss_sel_q, ss_sel_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [1:0]  done_q, done_d;
    logic        spi_wrt_q, spi_wrt_d;

    logic        win;
    logic        grant;
    logic        finish;
    logic        tmo_hit;
    logic        tmr_clr;
    logic        tmr_en;
    logic [CW-1:0] tmr_limit;
    logic        tmr_tc;

    // Both requesting: the one not served last wins. Otherwise the sole requester wins.
    assign win    = (req == 2'b11) ? ~last_q : req[REQ_A2D];
    assign grant  = (state_q == IDLE) && (|req);
    assign finish = (state_q == BUSY) && spi_done;

    // Counter restarts from zero on every state entry.
    assign tmr_clr = (state_d != state_q);

`ifdef SPI_ARB_TMO_EN
    localparam logic [CW-1:0] TMO_LIM = CW'(umax(TMO_CYCLES, 1) - 1);
    assign tmr_en    = (state_q == GUARD) || (state_q == BUSY);
    assign tmr_limit = (state_q == GUARD) ? GAP_LIM : TMO_LIM;
    assign tmo_hit   = (state_q == BUSY) && tmr_tc;
`else
    assign tmr_en    = (state_q == GUARD);
    assign tmr_limit = GAP_LIM;
    assign tmo_hit   = 1'b0;
`endif

    spi_arb_tmr #(
        .WIDTH (CW)
    ) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (|req) state_d = START;
            START: state_d = BUSY;
            BUSY: begin
                if (spi_done || tmo_hit) state_d = (GAP_CYCLES == 0) ? IDLE : GUARD;
            end
            GUARD: if (tmr_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        last_d    = last_q;
        gnt_d     = gnt_q;
        spi_cmd_d = spi_cmd_q;
        ss_sel_d  = ss_sel_q;
        rd_data_d = rd_data_q;
        done_d    = 2'b00;
        spi_wrt_d = (state_q == START);

        // gnt stays up through the done/err cycle, then drops; a new grant overrides.
        if ((|done_q) || (|err)) gnt_d = 2'b00;
        if (grant) begin
            gnt_d     = req_oh(win);
            spi_cmd_d = win ? cmd1 : cmd0;
            ss_sel_d  = win;
            last_d    = win;
        end
        if (finish) begin
            rd_data_d = spi_rd_data;
            done_d    = req_oh(ss_sel_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
            spi_cmd_q <= 16'h0000;
            ss_sel_q  <= 1'b0;
            rd_data_q <= 16'h0000;
            done_q    <= 2'b00;
            spi_wrt_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            spi_cmd_q <= spi_cmd_d;
            ss_sel_q  <= ss_sel_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            spi_wrt_q <= spi_wrt_d;
        end
    end

`ifdef SPI_ARB_TMO_EN
    logic [1:0] err_q, err_d;

    // spi_done on the abort clock is a normal completion, so the abort needs !spi_done.
    always_comb begin
        err_d = 2'b00;
        if (tmo_hit && !spi_done) err_d = req_oh(ss_sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 2'b00;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

    assign gnt     = gnt_q;
    assign spi_cmd = spi_cmd_q;
    assign ss_sel  = ss_sel_q;
    assign rd_data = rd_data_q;
    assign done    = done_q;
    assign spi_wrt = spi_wrt_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter (GAP_CYCLES = 4, TMO_CYCLES = 32).
// Inputs change and outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;

    localparam int unsigned GAP = 4;
    localparam int unsigned TMO = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] cmd0 = 16'h0000;
    logic [15:0] cmd1 = 16'h0000;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] rd_data;
    logic [1:0]  gnt;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd_data = 16'h0000;
    logic        ss_sel;

    spi_bus_arbiter #(
        .GAP_CYCLES (GAP),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .cmd0        (cmd0),
        .cmd1        (cmd1),
        .done        (done),
        .err         (err),
        .rd_data     (rd_data),
        .gnt         (gnt),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data),
        .ss_sel      (ss_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_rd = 16'h0000;

    typedef struct packed {
        logic [1:0]  req;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [15:0] rd;
        logic [1:0]  gnt;
        logic        ss;
        logic [15:0] cmd;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Ticks until a grant appears (bounded); also reports any spi_wrt seen while waiting.
    task automatic wait_gnt(output int n, output bit wrt_seen);
        n = 0;
        wrt_seen = 1'b0;
        while (gnt == 2'b00 && n < 40) begin
            tick();
            n++;
            if (spi_wrt) wrt_seen = 1'b1;
        end
    endtask

    task automatic wait_wrt(output int n);
        n = 0;
        while (!spi_wrt && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_txn(input string name, input logic [15:0] data, input logic [1:0] who);
        spi_done    = 1'b1;
        spi_rd_data = data;
        tick();
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        chk({name, "_done"}, {30'd0, done}, {30'd0, who});
        chk({name, "_rd_data"}, {16'd0, rd_data}, {16'd0, data});
        exp_rd = data;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        bit wseen;
        bit seen_err;
        bit seen_done;
        logic [1:0] eg;

        //          req    cmd0     cmd1     rd       gnt    ss    cmd
        vecs[0] = '{2'b01, 16'hA5C3, 16'h0000, 16'h1234, 2'b01, 1'b0, 16'hA5C3};
        vecs[1] = '{2'b10, 16'h1111, 16'h5A3C, 16'hBEEF, 2'b10, 1'b1, 16'h5A3C};
        vecs[2] = '{2'b11, 16'h0F01, 16'h0F02, 16'h0001, 2'b01, 1'b0, 16'h0F01};
        vecs[3] = '{2'b11, 16'h0F03, 16'h0F04, 16'h0002, 2'b10, 1'b1, 16'h0F04};
        vecs[4] = '{2'b01, 16'hCAFE, 16'hF00D, 16'h0003, 2'b01, 1'b0, 16'hCAFE};
        vecs[5] = '{2'b11, 16'h1357, 16'h2468, 16'h8001, 2'b10, 1'b1, 16'h2468};

        // Reset values
        tick();
        tick();
        chk("rst_gnt",     {30'd0, gnt},  32'd0);
        chk("rst_done",    {30'd0, done}, 32'd0);
        chk("rst_err",     {30'd0, err},  32'd0);
        chk("rst_spi_wrt", {31'd0, spi_wrt}, 32'd0);
        chk("rst_spi_cmd", {16'd0, spi_cmd}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_ss_sel",  {31'd0, ss_sel},  32'd0);
        rst_n = 1'b1;
        tick();

        // Single transactions from IDLE
        for (int i = 0; i < 6; i++) begin
            req  = vecs[i].req;
            cmd0 = vecs[i].c0;
            cmd1 = vecs[i].c1;
            tick();
            chk("vec_gnt",     {30'd0, gnt},     {30'd0, vecs[i].gnt});
            chk("vec_ss_sel",  {31'd0, ss_sel},  {31'd0, vecs[i].ss});
            chk("vec_spi_cmd", {16'd0, spi_cmd}, {16'd0, vecs[i].cmd});
            chk("vec_wrt_early", {31'd0, spi_wrt}, 32'd0);
            tick();
            chk("vec_wrt_2clk", {31'd0, spi_wrt}, 32'd1);
            tick();
            chk("vec_wrt_1pulse", {31'd0, spi_wrt}, 32'd0);
            repeat (13) tick();
            finish_txn("vec", vecs[i].rd, vecs[i].gnt);
            chk("vec_gnt_in_done", {30'd0, gnt}, {30'd0, vecs[i].gnt});
            req = 2'b00;
            tick();
            chk("vec_done_1clk", {30'd0, done}, 32'd0);
            chk("vec_gnt_clear", {30'd0, gnt},  32'd0);
            repeat (GAP + 1) tick();
        end

        // Both requests held: strict alternation with the guard gap between grants
        req  = 2'b11;
        cmd0 = 16'h0A0A;
        cmd1 = 16'h0B0B;
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            if (k == 0) begin
                wait_gnt(n, wseen);
                chk("alt_first_lat", n, 32'd1);
            end else begin
                tick();
                chk("alt_gnt_drop", {30'd0, gnt}, 32'd0);
                wait_gnt(n, wseen);
                chk("alt_gap", n + 1, GAP + 1);
                chk("alt_no_wrt_guard", {31'd0, wseen}, 32'd0);
            end
            chk("alt_gnt",    {30'd0, gnt},    {30'd0, eg});
            chk("alt_ss_sel", {31'd0, ss_sel}, {31'd0, eg[1]});
            chk("alt_cmd",    {16'd0, spi_cmd}, eg[1] ? 32'h0B0B : 32'h0A0A);
            wait_wrt(n);
            chk("alt_wrt_lat", n, 32'd1);
            repeat (2) tick();
            finish_txn("alt", 16'h7000 + 16'(k), eg);
        end
        req = 2'b00;
        repeat (GAP + 2) tick();

        // req[1] rises during requester 0's BUSY
        req  = 2'b01;
        cmd0 = 16'h3C3C;
        cmd1 = 16'h6677;
        wait_gnt(n, wseen);
        chk("pend_gnt0", {30'd0, gnt}, 32'd1);
        wait_wrt(n);
        repeat (3) tick();
        req = 2'b11;
        repeat (3) tick();
        finish_txn("pend0", 16'h4455, 2'b01);
        req = 2'b10;
        tick();
        wait_gnt(n, wseen);
        chk("pend_gap", n + 1, GAP + 1);
        chk("pend_no_wrt_guard", {31'd0, wseen}, 32'd0);
        chk("pend_gnt1", {30'd0, gnt}, 32'd2);
        chk("pend_cmd1", {16'd0, spi_cmd}, 32'h6677);
        wait_wrt(n);
        tick();
        finish_txn("pend1", 16'h8899, 2'b10);
        req = 2'b00;
        repeat (GAP + 2) tick();

        // Stray spi_done in IDLE, then req[0] dropped mid-BUSY
        spi_done    = 1'b1;
        spi_rd_data = 16'hFFFF;
        tick();
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        chk("stray_rd_data", {16'd0, rd_data}, {16'd0, exp_rd});
        chk("stray_done", {30'd0, done}, 32'd0);
        tick();
        chk("stray_gnt", {30'd0, gnt}, 32'd0);
        chk("stray_wrt", {31'd0, spi_wrt}, 32'd0);
        req  = 2'b01;
        cmd0 = 16'h1F1F;
        wait_gnt(n, wseen);
        wait_wrt(n);
        tick();
        req = 2'b00;
        repeat (3) tick();
        chk("drop_gnt_held", {30'd0, gnt}, 32'd1);
        finish_txn("drop", 16'h0F0F, 2'b01);
        repeat (GAP + 2) tick();

        // Reset in the middle of BUSY
        req  = 2'b10;
        cmd1 = 16'h4242;
        wait_gnt(n, wseen);
        wait_wrt(n);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_gnt",     {30'd0, gnt},     32'd0);
        chk("mrst_spi_cmd", {16'd0, spi_cmd}, 32'd0);
        chk("mrst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("mrst_ss_sel",  {31'd0, ss_sel},  32'd0);
        chk("mrst_done",    {30'd0, done},    32'd0);
        exp_rd = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        req   = 2'b11;
        cmd0  = 16'hD00D;
        wait_gnt(n, wseen);
        chk("post_rst_lat", n, 32'd1);
        chk("post_rst_gnt", {30'd0, gnt}, 32'd1);
        wait_wrt(n);
        tick();
        finish_txn("post_rst", 16'h2222, 2'b01);
        req = 2'b00;
        repeat (GAP + 2) tick();

        // Watchdog behaviour
        req  = 2'b01;
        cmd0 = 16'h5151;
        cmd1 = 16'h6161;
        wait_gnt(n, wseen);
        wait_wrt(n);
`ifdef SPI_ARB_TMO_EN
        req = 2'b11;
        n = 0;
        seen_done = 1'b0;
        while (err == 2'b00 && n < int'(TMO) + 20) begin
            tick();
            n++;
            if (done != 2'b00) seen_done = 1'b1;
        end
        chk("tmo_latency", n, TMO);
        chk("tmo_err", {30'd0, err}, 32'd1);
        chk("tmo_no_done", {31'd0, seen_done}, 32'd0);
        chk("tmo_rd_data", {16'd0, rd_data}, {16'd0, exp_rd});
        req = 2'b10;
        tick();
        chk("tmo_err_1clk", {30'd0, err}, 32'd0);
        wait_gnt(n, wseen);
        chk("tmo_gap", n + 1, GAP + 1);
        chk("tmo_next_gnt", {30'd0, gnt}, 32'd2);
        wait_wrt(n);
        tick();
        finish_txn("tmo_next", 16'h3333, 2'b10);
`else
        seen_err  = 1'b0;
        seen_done = 1'b0;
        repeat (TMO + 10) begin
            tick();
            if (err != 2'b00) seen_err = 1'b1;
            if (done != 2'b00) seen_done = 1'b1;
        end
        chk("notmo_no_err", {31'd0, seen_err}, 32'd0);
        chk("notmo_no_done", {31'd0, seen_done}, 32'd0);
        chk("notmo_gnt_held", {30'd0, gnt}, 32'd1);
        finish_txn("notmo", 16'h3333, 2'b01);
`endif
        req = 2'b00;
        repeat (GAP + 2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
